// File: rtl/instr_sequencer_pkg.sv
// Shared parameters for the instruction sequencer: data width and one-hot state encodings.
package instr_sequencer_pkg;

    localparam int WORD_SIZE = 16;

    typedef enum logic [5:0] {
        ST_BOOT      = 6'b000001,
        ST_FETCH     = 6'b000010,
        ST_DECODE    = 6'b000100,
        ST_EXECUTE   = 6'b001000,
        ST_WRITEBACK = 6'b010000,
        ST_HALT      = 6'b100000
    } state_t;

    // Bit positions inside the one-hot state vector, used for direct phase decode.
    localparam int FETCH_IDX     = 1;
    localparam int DECODE_IDX    = 2;
    localparam int EXECUTE_IDX   = 3;
    localparam int WRITEBACK_IDX = 4;
    localparam int HALT_IDX      = 5;

endpackage

// File: rtl/instr_sequencer_pc_reg.sv
// Program counter register: loads a target or increments when enabled.
// Latency: new value visible the cycle after upd_en. Backpressure: none, holds when upd_en low.
// Wraps modulo 2^W on increment.
module instr_sequencer_pc_reg #(
    parameter int             W            = 16,
    parameter logic [W-1:0]   RESET_VECTOR = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         upd_en,
    input  logic         load_target,
    input  logic [W-1:0] target,
    output logic [W-1:0] pc
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (upd_en) begin
            pc_d = load_target ? target : pc_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_sequencer.sv
// Four-phase instruction sequencer owning the PC, with branch, halt/resume and retire count.
// Latency: 4 cycles per instruction unstalled, +1 per stall cycle; HALT->FETCH 1 cycle after resume.
// Backpressure: stall holds the current phase (not in BOOT/HALT); no state captured while held.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_target,
    input  logic                 halt,
    input  logic                 resume,
    output logic [WORD_SIZE-1:0] pointer,
    output logic                 fetch_enable,
    output logic                 decode_enable,
    output logic                 execute_enable,
    output logic                 writeback_enable,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] retired
);

    state_t                 state_q, state_d;
    logic                   br_pending_q, br_pending_d;
    logic [WORD_SIZE-1:0]   br_target_q, br_target_d;
    logic                   halt_pending_q, halt_pending_d;
    logic [WORD_SIZE-1:0]   retired_q, retired_d;
    logic                   leave_ex;
    logic                   leave_wb;

    assign leave_ex = (state_q == ST_EXECUTE)   && !stall;
    assign leave_wb = (state_q == ST_WRITEBACK) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_BOOT;
            br_pending_q   <= 1'b0;
            br_target_q    <= '0;
            halt_pending_q <= 1'b0;
            retired_q      <= '0;
        end else begin
            state_q        <= state_d;
            br_pending_q   <= br_pending_d;
            br_target_q    <= br_target_d;
            halt_pending_q <= halt_pending_d;
            retired_q      <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:      state_d = ST_FETCH;
            ST_FETCH:     if (!stall) state_d = ST_DECODE;
            ST_DECODE:    if (!stall) state_d = ST_EXECUTE;
            ST_EXECUTE:   if (!stall) state_d = ST_WRITEBACK;
            ST_WRITEBACK: if (!stall) state_d = halt_pending_q ? ST_HALT : ST_FETCH;
            ST_HALT:      if (resume) state_d = ST_FETCH;
            default:      state_d = ST_BOOT;
        endcase
    end

    // Pending flags are set on the EXECUTE exit edge and consumed on the WRITEBACK exit edge.
    always_comb begin
        br_pending_d   = br_pending_q;
        br_target_d    = br_target_q;
        halt_pending_d = halt_pending_q;
        retired_d      = retired_q;
        if (leave_ex) begin
            br_pending_d   = branch_taken;
            br_target_d    = branch_target;
            halt_pending_d = halt;
        end
        if (leave_wb) begin
            br_pending_d   = 1'b0;
            halt_pending_d = 1'b0;
            retired_d      = retired_q + WORD_SIZE'(1);
        end
    end

    always_comb begin
        fetch_enable     = state_q[FETCH_IDX];
        decode_enable    = state_q[DECODE_IDX];
        execute_enable   = state_q[EXECUTE_IDX];
        writeback_enable = state_q[WRITEBACK_IDX];
        halted           = state_q[HALT_IDX];
        retired          = retired_q;
    end

    instr_sequencer_pc_reg #(
        .W            (WORD_SIZE),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_en      (leave_wb),
        .load_target (br_pending_q),
        .target      (br_target_q),
        .pc          (pointer)
    );

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control sequencer directly upstream of the instruction fetcher. Owns the program counter and drives `pointer` and `fetch_enable` into the fetch stage. Steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK, and emits one phase-enable per stage. Handles branches, execute stalls, halt/resume, and counts retired instructions.

## Interface
- `WORD_SIZE`, 16: data/address width; comes from the shared parameters file.
- `RESET_VECTOR`, 0: `pointer` value after reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `stall`  in  1  holds the current phase; ignored in BOOT and HALT.
- `branch_taken`  in  1  sampled on the edge leaving EXECUTE.
- `branch_target`  in  WORD_SIZE  next PC when `branch_taken`; sampled with it.
- `halt`  in  1  sampled on the edge leaving EXECUTE; enters HALT after WRITEBACK.
- `resume`  in  1  in HALT, moves to FETCH on the next edge.
- `pointer`  out  WORD_SIZE  current PC, fed to the fetcher.
- `fetch_enable`  out  1  high only in FETCH.
- `decode_enable`  out  1  high only in DECODE.
- `execute_enable`  out  1  high only in EXECUTE.
- `writeback_enable`  out  1  high only in WRITEBACK.
- `halted`  out  1  high only in HALT.
- `retired`  out  WORD_SIZE  count of completed WRITEBACKs.

## Operation
- States: BOOT, FETCH, DECODE, EXECUTE, WRITEBACK, HALT. One-hot encoding.
- Phase enables and `halted` are decoded from the state register only. They are glitch-free and mutually exclusive.
- Transitions:
  - BOOT→FETCH unconditionally.
  - FETCH→DECODE→EXECUTE→WRITEBACK when `stall`=0. With `stall`=1 the state is held and its enable stays high.
  - WRITEBACK→HALT if `halt_pending`, otherwise →FETCH.
  - HALT→FETCH when `resume`=1.
- Leaving EXECUTE captures three internal registers: `br_pending`←`branch_taken`, `br_target`←`branch_target`, `halt_pending`←`halt`. If EXECUTE is held by `stall`, nothing is captured.
- Leaving WRITEBACK (to FETCH or HALT):
  - `pointer` ← `br_target` if `br_pending`, else `pointer`+1, modulo 2^WORD_SIZE. All-ones wraps to 0.
  - `retired` increments, modulo 2^WORD_SIZE.
  - `br_pending` and `halt_pending` clear.
- Simultaneous `halt` and `branch_taken`: both are honoured. The halted PC is `branch_target`.
- `resume` outside HALT is ignored. `halt` and `branch_*` outside the EXECUTE exit edge are ignored.
- `stall` during WRITEBACK delays the PC update and the `retired` increment until the edge that actually leaves WRITEBACK.

## Timing
- Reset values: state BOOT, `pointer`=RESET_VECTOR, `retired`=0, all enables 0, `halted`=0, pending registers 0.
- Reset assertion mid-instruction returns to BOOT immediately, asynchronously. Any partially executed instruction is discarded and is not counted.
- First FETCH is the first cycle after the first rising edge following `rst_n` release.
- Unstalled throughput is one instruction per 4 cycles. Each stall cycle adds one cycle.
- `pointer` is stable for the whole FETCH cycle. The fetcher latches on the edge that ends FETCH.
- The new `pointer` is visible in the first cycle of the next FETCH, or in the first HALT cycle.
- HALT→FETCH takes 1 cycle after `resume` is sampled high.

## Structure
- State encodings go in the shared parameters file alongside WORD_SIZE, so the decoder and execute blocks can reference them.
- `RESET_VECTOR` stays a module parameter.
- One sub-module is natural: `pc_reg`. It is the PC register with async reset, a load-target/increment select, and an update-enable.
- The FSM, pending registers and retire counter stay in `instr_sequencer`.

## Test plan
- **Reset/startup:** release `rst_n`, no stalls, 8 cycles → `pointer` 0,0,0,0,1,1,1,1. `fetch_enable` high at cycles 1 and 5. `retired`=1 after cycle 4.
- **Branch:** at PC 3, `branch_taken`=1, `branch_target`=0x0040 during EXECUTE → next FETCH `pointer`=0x0040. Asserting `branch_taken` in DECODE only has no effect (PC 4).
- **Stall:** `stall`=1 for 3 cycles in EXECUTE → `execute_enable` high for 4 cycles. Instruction period is 7. `retired` increments once.
- **Halt/resume:** `halt`=1 in EXECUTE at PC 5 → after WRITEBACK, `halted`=1, `pointer`=6, all enables 0. `resume` pulse → FETCH at PC 6 the next cycle.
- **Wrap:** `RESET_VECTOR`=0xFFFF → after the first instruction, `pointer`=0x0000.
- **Mid-op reset:** drop `rst_n` during EXECUTE with `branch_taken`=1 → `pointer`=RESET_VECTOR and `retired`=0 immediately. After release, the sequence restarts from BOOT.
